grid_renderer: RTL and testbench
================================

# grid_renderer

Parametrised, pipelined successor to the 4×4 board renderer. It maps the VGA scan position to a 12-bit colour for an R×C grid of coloured cells with gaps, row and column indicator marks, and a border. It adds a blinking cursor outline and a timed error flash. It sits between the VGA timing generator (x, y, videoOn) and the RGB output pins.

## Interface
- ROWS, 4: grid rows
- COLS, 4: grid columns
- CELL_W, 100: cell edge in pixels
- GAP_W, 4: gap width in pixels
- ORG_X, 110: left border width
- ORG_Y, 30: top border height
- MARK_L, 11: indicator mark length
- MARK_H, 4: indicator mark thickness
- OUTL_W, 3: cursor outline thickness
- BLINK_FRAMES, 30: frames per cursor blink phase
- FLASH_FRAMES, 8: frames of error flash
- clk  in  1  pixel clock; one clock domain; reset is asynchronous, active-high
- reset  in  1  asynchronous active-high reset
- x, y  in  10 each  scan position
- videoOn  in  1  active-video flag
- cells  in  ROWS·COLS·12  cell (r,c) colour at [(r·COLS+c)·12 +: 12]
- row_sel  in  ROWS  one-hot/any-hot row marks
- col_sel  in  COLS  column marks
- cursor_en  in  1  enable cursor outline
- cursor_row, cursor_col  in  $clog2(ROWS), $clog2(COLS)  cursor cell
- error  in  1  error condition
- rgb  out  12  registered colour

## Operation
- Axis decode uses pitch P = GAP_W + CELL_W, with all bounds lower-exclusive and upper-inclusive.
  - Gap k: ORG_X + k·P < x ≤ ORG_X + k·P + GAP_W, for k = 0..COLS.
  - Cell k: ORG_X + k·P + GAP_W < x ≤ ORG_X + (k+1)·P.
  - y uses the same rules with ORG_Y and ROWS.
- Region priority:
  1. !videoOn gives 000.
  2. A gap on either axis (both axes inside grid span) gives 7FF.
  3. A cell gives the cursor colour FFF when the cursor is active, the pixel is in cell (cursor_row, cursor_col), and the offset from any cell edge is < OUTL_W. Otherwise it gives the cells colour.
  4. Column mark: ORG_Y−MARK_H−MARK_L < y ≤ ORG_Y−MARK_H, and |x − centre(col k)| within (−MARK_H/2, MARK_H/2], and col_sel[k] set. Gives 8E8.
  5. Row mark: ORG_X/2−MARK_L/2 < x ≤ ORG_X/2+MARK_L/2, y within the centre band of row k, and row_sel[k] set. Gives 8E8.
  6. Otherwise the border colour.
- Frame tick: one cycle when the sampled x==0 && y==0.
- Cursor blink:
  - The frame counter counts ticks to BLINK_FRAMES−1, then wraps and toggles blink_phase.
  - The cursor is active when cursor_en && blink_phase==1.
  - Changing cursor_row or cursor_col does not reset the phase.
- Error border FSM:
  - IDLE: border 606. A rising edge of error (error & !error_q) goes to FLASH, with flash_cnt=0.
  - FLASH: border A30 when flash_cnt is even, 606 when odd. flash_cnt increments on each frame tick. It goes to HOLD when flash_cnt reaches FLASH_FRAMES−1 on a tick.
  - HOLD: border A30 while error is high.
  - error low in any state goes to IDLE on the next clock. A new rising edge in FLASH or HOLD restarts FLASH.
- Elaboration fails when ORG_X + (COLS+1)·GAP_W + COLS·CELL_W > 639 or ORG_Y + (ROWS+1)·GAP_W + ROWS·CELL_W > 479.

## Timing
- Two-stage pipeline:
  - Stage 1 registers region code, cell index, edge-offset flag, mark hit and videoOn.
  - Stage 2 registers rgb.
  - Latency from x/y/videoOn to rgb is exactly 2 clocks, throughput 1 pixel per clock.
- cells, row_sel, col_sel are sampled in stage 2. The blink and border states are sampled in stage 2.
- Reset values: rgb=000, all stage registers 0 (stage videoOn=0), blink_phase=0, frame counter 0, FSM IDLE, flash_cnt 0, error_q 0.
- After reset with error held high, error_q=0 counts as a rising edge, so FLASH restarts.
- Reset mid-frame forces rgb=000 immediately (asynchronous). Valid output resumes 2 clocks after deassertion.

## Structure
- display_pkg holds:
  - colour constants: GAP_COLOR 7FF, MARK_COLOR 8E8, BORDER_DEFAULT 606, BORDER_ERROR A30, CURSOR_COLOR FFF
  - region enum: BORDER, GAP, CELL, MARK
  - error FSM state enum: IDLE, FLASH, HOLD
- Sub-module grid_axis_decode(N, ORG, CELL_W, GAP_W, OUTL_W), instantiated for x (N=COLS) and y (N=ROWS). It is combinational: in_span, is_gap, index, near_edge.

## Test plan
- Reset, then cells[11:0]=F00 and x=160, y=84, videoOn=1: rgb=000 during reset, then F00 two clocks after the stimulus.
- x=112,y=84 → 7FF; x=110 → 606; x=530 → 7FF; x=531 → 606; videoOn=0 at x=160 → 000.
- col_sel=0001, y=20, x=164 → 8E8; col_sel=0000 → 606. row_sel=0010, x=55, y=186 → 8E8.
- cursor_en=1, cursor (1,2), BLINK_FRAMES=2, cell (1,2)=0F0:
  - x=323, y=180 alternates FFF/0F0 every 2 frame ticks, starting 0F0.
  - x=370, y=180 is always 0F0.
- FLASH_FRAMES=4, error rises and stays high, sampled at x=5, y=5:
  - A30, 606, A30, 606 over four frames, then steady A30.
  - error low → 606 within 3 clocks.
- Reset asserted during FLASH with error still high: rgb=000 while asserted; after release, the flash sequence restarts with A30.

Source files
------------

// File: rtl/display_pkg.sv
// Shared colours, region codes and error-border FSM states for the grid renderer.
package display_pkg;

  localparam logic [11:0] GAP_COLOR      = 12'h7FF;
  localparam logic [11:0] MARK_COLOR     = 12'h8E8;
  localparam logic [11:0] BORDER_DEFAULT = 12'h606;
  localparam logic [11:0] BORDER_ERROR   = 12'hA30;
  localparam logic [11:0] CURSOR_COLOR   = 12'hFFF;
  localparam logic [11:0] BLANK_COLOR    = 12'h000;

  // What the stage-1 pixel falls on; MARK still needs the select bit in stage 2.
  typedef enum logic [1:0] {BORDER, GAP, CELL, MARK} region_t;

  // Error border state: IDLE steady, FLASH alternating, HOLD steady error colour.
  typedef enum logic [1:0] {IDLE, FLASH, HOLD} err_state_t;

endpackage

// File: rtl/grid_axis_decode.sv
// One-axis decode of a scan coordinate into gap / cell index / outline-edge flags.
// Bounds are lower-exclusive, upper-inclusive: the span starts just after ORG.
module grid_axis_decode #(
  parameter int N      = 4,
  parameter int ORG    = 110,
  parameter int CELL_W = 100,
  parameter int GAP_W  = 4,
  parameter int OUTL_W = 3,
  parameter int IW     = (N > 1) ? $clog2(N) : 1
) (
  input  logic [9:0]    pos,
  output logic          in_span,
  output logic          is_gap,
  output logic [IW-1:0] index,
  output logic          near_edge
);

  localparam int P    = GAP_W + CELL_W;
  localparam int SPAN = N * P + GAP_W;

  int rel;
  int k;
  int off;
  int co;

  // rel is the 0-based offset into the span; each pitch is gap first, then cell.
  always_comb begin
    rel     = int'({22'd0, pos}) - ORG - 1;
    in_span = (rel >= 0) && (rel < SPAN);
    k       = 0;
    for (int i = 1; i <= N; i++) begin
      if (rel >= i * P) k = i;
    end
    off       = rel - k * P;
    co        = off - GAP_W;
    is_gap    = in_span && (off < GAP_W);
    index     = '0;
    near_edge = 1'b0;
    if (in_span && !is_gap) begin
      index     = IW'(k);
      near_edge = (co < OUTL_W) || (co >= CELL_W - OUTL_W);
    end
  end

endmodule

// File: rtl/grid_renderer.sv
// Two-stage pixel renderer for an R x C board: cells, gaps, row/column marks,
// blinking cursor outline and an error-flashing border.
module grid_renderer
  import display_pkg::*;
#(
  parameter int ROWS         = 4,
  parameter int COLS         = 4,
  parameter int CELL_W       = 100,
  parameter int GAP_W        = 4,
  parameter int ORG_X        = 110,
  parameter int ORG_Y        = 30,
  parameter int MARK_L       = 11,
  parameter int MARK_H       = 4,
  parameter int OUTL_W       = 3,
  parameter int BLINK_FRAMES = 30,
  parameter int FLASH_FRAMES = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [9:0]               x,
  input  logic [9:0]               y,
  input  logic                     videoOn,
  input  logic [ROWS*COLS*12-1:0]  cells,
  input  logic [ROWS-1:0]          row_sel,
  input  logic [COLS-1:0]          col_sel,
  input  logic                     cursor_en,
  input  logic [$clog2(ROWS)-1:0]  cursor_row,
  input  logic [$clog2(COLS)-1:0]  cursor_col,
  input  logic                     error,
  output logic [11:0]              rgb
);

  localparam int P  = GAP_W + CELL_W;
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int FW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

  if (ORG_X + (COLS + 1) * GAP_W + COLS * CELL_W > 639) begin : g_bad_x
    $error("grid_renderer: grid does not fit in 640 columns");
  end
  if (ORG_Y + (ROWS + 1) * GAP_W + ROWS * CELL_W > 479) begin : g_bad_y
    $error("grid_renderer: grid does not fit in 480 lines");
  end

  logic          x_in, x_gap, x_near, y_in, y_gap, y_near;
  logic [CW-1:0] x_idx;
  logic [RW-1:0] y_idx;

  grid_axis_decode #(.N(COLS), .ORG(ORG_X), .CELL_W(CELL_W), .GAP_W(GAP_W), .OUTL_W(OUTL_W), .IW(CW))
    u_x_dec (.pos(x), .in_span(x_in), .is_gap(x_gap), .index(x_idx), .near_edge(x_near));

  grid_axis_decode #(.N(ROWS), .ORG(ORG_Y), .CELL_W(CELL_W), .GAP_W(GAP_W), .OUTL_W(OUTL_W), .IW(RW))
    u_y_dec (.pos(y), .in_span(y_in), .is_gap(y_gap), .index(y_idx), .near_edge(y_near));

  // Mark geometry; the mark band is centred on the pitch centre of each row/column.
  int            xi, yi, ctr;
  logic          mcol_hit, mrow_hit;
  logic [CW-1:0] mcol_idx;
  logic [RW-1:0] mrow_idx;

  // Locate column marks above the grid and row marks left of it.
  always_comb begin
    xi       = int'({22'd0, x});
    yi       = int'({22'd0, y});
    ctr      = 0;
    mcol_hit = 1'b0;
    mcol_idx = '0;
    mrow_hit = 1'b0;
    mrow_idx = '0;
    if ((yi > ORG_Y - MARK_H - MARK_L) && (yi <= ORG_Y - MARK_H)) begin
      for (int k = 0; k < COLS; k++) begin
        ctr = ORG_X + k * P + P / 2;
        if ((xi > ctr - MARK_H / 2) && (xi <= ctr + MARK_H / 2)) begin
          mcol_hit = 1'b1;
          mcol_idx = CW'(k);
        end
      end
    end
    if ((xi > ORG_X / 2 - MARK_L / 2) && (xi <= ORG_X / 2 + MARK_L / 2)) begin
      for (int k = 0; k < ROWS; k++) begin
        ctr = ORG_Y + k * P + P / 2;
        if ((yi > ctr - MARK_H / 2) && (yi <= ctr + MARK_H / 2)) begin
          mrow_hit = 1'b1;
          mrow_idx = RW'(k);
        end
      end
    end
  end

  region_t       region_d, s1_region;
  logic [RW-1:0] row_d, s1_row;
  logic [CW-1:0] col_d, s1_col;
  logic          s1_near, s1_mcol, s1_mrow, s1_video;

  // Region priority: gap, then cell, then mark candidate, else border.
  always_comb begin
    region_d = BORDER;
    row_d    = '0;
    col_d    = '0;
    if (x_in && y_in && (x_gap || y_gap)) begin
      region_d = GAP;
    end else if (x_in && y_in) begin
      region_d = CELL;
      row_d    = y_idx;
      col_d    = x_idx;
    end else if (mcol_hit || mrow_hit) begin
      region_d = MARK;
      row_d    = mrow_idx;
      col_d    = mcol_idx;
    end
  end

  // Stage 1: geometry of the current scan position.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_region <= BORDER;
      s1_row    <= '0;
      s1_col    <= '0;
      s1_near   <= 1'b0;
      s1_mcol   <= 1'b0;
      s1_mrow   <= 1'b0;
      s1_video  <= 1'b0;
    end else begin
      s1_region <= region_d;
      s1_row    <= row_d;
      s1_col    <= col_d;
      s1_near   <= x_near || y_near;
      s1_mcol   <= mcol_hit && (region_d == MARK);
      s1_mrow   <= mrow_hit && (region_d == MARK);
      s1_video  <= videoOn;
    end
  end

  logic          frame_tick;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;

  assign frame_tick = (x == 10'd0) && (y == 10'd0);

  // Blink timer: toggle phase every BLINK_FRAMES frame ticks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_tick) begin
      if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  err_state_t    err_state, err_state_d;
  logic [FW-1:0] flash_cnt, flash_cnt_d;
  logic          error_q;
  logic [11:0]   border_color;

  // Error FSM state and edge-detect registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_state <= IDLE;
      flash_cnt <= '0;
      error_q   <= 1'b0;
    end else begin
      err_state <= err_state_d;
      flash_cnt <= flash_cnt_d;
      error_q   <= error;
    end
  end

  // Error FSM next state and border colour; a fresh rising edge always restarts the flash.
  always_comb begin
    err_state_d  = err_state;
    flash_cnt_d  = flash_cnt;
    border_color = BORDER_DEFAULT;
    if (!error) begin
      err_state_d = IDLE;
      flash_cnt_d = '0;
    end else if (!error_q) begin
      err_state_d = FLASH;
      flash_cnt_d = '0;
    end else if ((err_state == FLASH) && frame_tick) begin
      if (flash_cnt == FW'(FLASH_FRAMES - 1)) err_state_d = HOLD;
      else                                     flash_cnt_d = flash_cnt + 1'b1;
    end
    case (err_state)
      FLASH:   border_color = flash_cnt[0] ? BORDER_DEFAULT : BORDER_ERROR;
      HOLD:    border_color = BORDER_ERROR;
      default: border_color = BORDER_DEFAULT;
    endcase
  end

  logic [11:0] pix_d;
  int          cell_base;

  // Stage 2 colour select using live cell/select/cursor inputs.
  always_comb begin
    cell_base = (int'(s1_row) * COLS + int'(s1_col)) * 12;
    pix_d     = border_color;
    if (!s1_video) begin
      pix_d = BLANK_COLOR;
    end else begin
      case (s1_region)
        GAP:  pix_d = GAP_COLOR;
        CELL: begin
          if (cursor_en && blink_phase && s1_near &&
              (s1_row == cursor_row) && (s1_col == cursor_col))
            pix_d = CURSOR_COLOR;
          else
            pix_d = cells[cell_base +: 12];
        end
        MARK: begin
          if ((s1_mcol && col_sel[s1_col]) || (s1_mrow && row_sel[s1_row]))
            pix_d = MARK_COLOR;
        end
        default: pix_d = border_color;
      endcase
    end
  end

  // Stage 2 output register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rgb <= BLANK_COLOR;
    else       rgb <= pix_d;
  end

endmodule

// File: tb/tb_grid_renderer.sv
// Self-checking bench for grid_renderer with a spec-level pixel model.
module tb_grid_renderer;

  localparam int ROWS = 4, COLS = 4, CELL_W = 100, GAP_W = 4;
  localparam int ORG_X = 110, ORG_Y = 30, MARK_L = 11, MARK_H = 4, OUTL_W = 3;
  localparam int BLINK_FRAMES = 2, FLASH_FRAMES = 4;
  localparam int P = GAP_W + CELL_W;

  logic                    clk, reset, videoOn, cursor_en, error;
  logic [9:0]              x, y;
  logic [ROWS*COLS*12-1:0] cells;
  logic [ROWS-1:0]         row_sel;
  logic [COLS-1:0]         col_sel;
  logic [1:0]              cursor_row, cursor_col;
  logic [11:0]             rgb;

  int n_checks, n_fail;
  int m_ticks, m_rise;
  bit m_err;

  grid_renderer #(
    .ROWS(ROWS), .COLS(COLS), .CELL_W(CELL_W), .GAP_W(GAP_W), .ORG_X(ORG_X), .ORG_Y(ORG_Y),
    .MARK_L(MARK_L), .MARK_H(MARK_H), .OUTL_W(OUTL_W),
    .BLINK_FRAMES(BLINK_FRAMES), .FLASH_FRAMES(FLASH_FRAMES)
  ) dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .videoOn(videoOn), .cells(cells),
    .row_sel(row_sel), .col_sel(col_sel), .cursor_en(cursor_en),
    .cursor_row(cursor_row), .cursor_col(cursor_col), .error(error), .rgb(rgb)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [11:0] m_border();
    int n;
    if (!m_err) return 12'h606;
    n = m_ticks - m_rise;
    if (n < FLASH_FRAMES) return (n % 2 == 0) ? 12'hA30 : 12'h606;
    return 12'hA30;
  endfunction

  function automatic logic [11:0] ref_pixel(int px, int py, bit v);
    bit xg, xc, yg, yc, xn, yn, phase;
    int xk, yk, lo, c;
    xg = 0; xc = 0; yg = 0; yc = 0; xn = 0; yn = 0; xk = 0; yk = 0;
    phase = ((m_ticks / BLINK_FRAMES) % 2) == 1;
    if (!v) return 12'h000;
    for (int k = 0; k <= COLS; k++) begin
      lo = ORG_X + k * P;
      if (px > lo && px <= lo + GAP_W) xg = 1;
    end
    for (int k = 0; k < COLS; k++) begin
      lo = ORG_X + k * P + GAP_W;
      if (px > lo && px <= lo + CELL_W) begin
        xc = 1; xk = k;
        xn = (px - lo - 1 < OUTL_W) || (lo + CELL_W - px < OUTL_W);
      end
    end
    for (int k = 0; k <= ROWS; k++) begin
      lo = ORG_Y + k * P;
      if (py > lo && py <= lo + GAP_W) yg = 1;
    end
    for (int k = 0; k < ROWS; k++) begin
      lo = ORG_Y + k * P + GAP_W;
      if (py > lo && py <= lo + CELL_W) begin
        yc = 1; yk = k;
        yn = (py - lo - 1 < OUTL_W) || (lo + CELL_W - py < OUTL_W);
      end
    end
    if ((xg || xc) && (yg || yc) && (xg || yg)) return 12'h7FF;
    if (xc && yc) begin
      if (cursor_en && phase && yk == int'(cursor_row) && xk == int'(cursor_col) && (xn || yn))
        return 12'hFFF;
      return cells[(yk * COLS + xk) * 12 +: 12];
    end
    if (py > ORG_Y - MARK_H - MARK_L && py <= ORG_Y - MARK_H) begin
      for (int k = 0; k < COLS; k++) begin
        c = ORG_X + k * P + P / 2;
        if (px - c > -(MARK_H / 2) && px - c <= MARK_H / 2 && col_sel[k]) return 12'h8E8;
      end
    end
    if (px > ORG_X / 2 - MARK_L / 2 && px <= ORG_X / 2 + MARK_L / 2) begin
      for (int k = 0; k < ROWS; k++) begin
        c = ORG_Y + k * P + P / 2;
        if (py - c > -(MARK_H / 2) && py - c <= MARK_H / 2 && row_sel[k]) return 12'h8E8;
      end
    end
    return m_border();
  endfunction

  // ---------------- driver tasks ----------------
  task automatic show(int px, int py, bit v);
    @(negedge clk);
    x = 10'(px); y = 10'(py); videoOn = v;
    repeat (2) @(negedge clk);
  endtask

  task automatic tick();
    @(negedge clk);
    x = 10'd0; y = 10'd0;
    @(negedge clk);
    x = 10'd1; y = 10'd1;
    m_ticks++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [11:0] exp;
    @(negedge clk);
    reset = 1'b1;
    cells[11:0] = 12'hF00;
    x = 10'd160; y = 10'd84; videoOn = 1'b1;
    #1;
    n_checks++;
    if (rgb !== 12'h000) begin n_fail++; $display("FAIL reset_assert: rgb=%h expected %h", rgb, 12'h000); end
    repeat (2) @(negedge clk);
    n_checks++;
    if (rgb !== 12'h000) begin n_fail++; $display("FAIL reset_hold: rgb=%h expected %h", rgb, 12'h000); end
    reset = 1'b0;
    m_ticks = 0; m_err = 0;
    repeat (2) @(negedge clk);
    exp = ref_pixel(160, 84, 1);
    n_checks++;
    if (rgb !== exp || rgb !== 12'hF00) begin n_fail++; $display("FAIL reset_first_pixel: rgb=%h expected %h", rgb, 12'hF00); end
  endtask

  task automatic test_regions();
    int          tx[5]   = '{112, 110, 530, 531, 160};
    bit          tv[5]   = '{1, 1, 1, 1, 0};
    logic [11:0] texp[5] = '{12'h7FF, 12'h606, 12'h7FF, 12'h606, 12'h000};
    for (int i = 0; i < 5; i++) begin
      show(tx[i], 84, tv[i]);
      n_checks++;
      if (rgb !== texp[i]) begin n_fail++; $display("FAIL region_x%0d: rgb=%h expected %h", tx[i], rgb, texp[i]); end
    end
  endtask

  task automatic test_marks();
    col_sel = 4'b0001;
    show(164, 20, 1);
    n_checks++;
    if (rgb !== 12'h8E8) begin n_fail++; $display("FAIL col_mark_on: rgb=%h expected %h", rgb, 12'h8E8); end
    col_sel = 4'b0000;
    show(164, 20, 1);
    n_checks++;
    if (rgb !== 12'h606) begin n_fail++; $display("FAIL col_mark_off: rgb=%h expected %h", rgb, 12'h606); end
    row_sel = 4'b0010;
    show(55, 186, 1);
    n_checks++;
    if (rgb !== 12'h8E8) begin n_fail++; $display("FAIL row_mark_on: rgb=%h expected %h", rgb, 12'h8E8); end
    row_sel = 4'b0000;
    show(55, 186, 1);
    n_checks++;
    if (rgb !== 12'h606) begin n_fail++; $display("FAIL row_mark_off: rgb=%h expected %h", rgb, 12'h606); end
  endtask

  task automatic test_cursor();
    logic [11:0] exp;
    cursor_en = 1'b1; cursor_row = 2'd1; cursor_col = 2'd2;
    cells[(1 * COLS + 2) * 12 +: 12] = 12'h0F0;
    for (int f = 0; f < 6; f++) begin
      exp = ((m_ticks / BLINK_FRAMES) % 2 == 1) ? 12'hFFF : 12'h0F0;
      show(323, 180, 1);
      n_checks++;
      if (rgb !== exp) begin n_fail++; $display("FAIL cursor_edge_f%0d: rgb=%h expected %h", f, rgb, exp); end
      show(370, 180, 1);
      n_checks++;
      if (rgb !== 12'h0F0) begin n_fail++; $display("FAIL cursor_inner_f%0d: rgb=%h expected %h", f, rgb, 12'h0F0); end
      tick();
    end
    cursor_row = 2'd3;
    show(323, 180, 1);
    exp = ref_pixel(323, 180, 1);
    n_checks++;
    if (rgb !== exp) begin n_fail++; $display("FAIL cursor_moved: rgb=%h expected %h", rgb, exp); end
    cursor_en = 1'b0;
  endtask

  task automatic test_error();
    logic [11:0] seq[7] = '{12'hA30, 12'h606, 12'hA30, 12'h606, 12'hA30, 12'hA30, 12'hA30};
    @(negedge clk);
    error = 1'b1; m_err = 1; m_rise = m_ticks;
    for (int f = 0; f < 7; f++) begin
      show(5, 5, 1);
      n_checks++;
      if (rgb !== seq[f] || rgb !== m_border()) begin
        n_fail++; $display("FAIL error_flash_f%0d: rgb=%h expected %h", f, rgb, seq[f]);
      end
      tick();
    end
    show(5, 5, 1);
    @(negedge clk);
    error = 1'b0; m_err = 0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (rgb !== 12'h606) begin n_fail++; $display("FAIL error_clear: rgb=%h expected %h", rgb, 12'h606); end
  endtask

  task automatic test_reset_flash();
    @(negedge clk);
    error = 1'b1; m_err = 1; m_rise = m_ticks;
    show(5, 5, 1);
    n_checks++;
    if (rgb !== 12'hA30) begin n_fail++; $display("FAIL rflash_start: rgb=%h expected %h", rgb, 12'hA30); end
    tick();
    show(5, 5, 1);
    n_checks++;
    if (rgb !== 12'h606) begin n_fail++; $display("FAIL rflash_odd: rgb=%h expected %h", rgb, 12'h606); end
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (rgb !== 12'h000) begin n_fail++; $display("FAIL rflash_async: rgb=%h expected %h", rgb, 12'h000); end
    repeat (2) @(negedge clk);
    n_checks++;
    if (rgb !== 12'h000) begin n_fail++; $display("FAIL rflash_hold: rgb=%h expected %h", rgb, 12'h000); end
    reset = 1'b0;
    m_ticks = 0; m_rise = 0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (rgb !== 12'hA30) begin n_fail++; $display("FAIL rflash_restart: rgb=%h expected %h", rgb, 12'hA30); end
    tick();
    show(5, 5, 1);
    n_checks++;
    if (rgb !== 12'h606) begin n_fail++; $display("FAIL rflash_second: rgb=%h expected %h", rgb, 12'h606); end
    @(negedge clk);
    error = 1'b0; m_err = 0;
    @(negedge clk);
  endtask

  task automatic test_random();
    int px, py;
    bit v;
    logic [11:0] exp;
    for (int i = 0; i < ROWS * COLS; i++) cells[i * 12 +: 12] = 12'($urandom);
    cursor_en = 1'b1;
    cursor_row = 2'($urandom_range(0, 3));
    cursor_col = 2'($urandom_range(0, 3));
    for (int n = 0; n < 80; n++) begin
      row_sel = 4'($urandom); col_sel = 4'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        px = ORG_X + int'(cursor_col) * P + GAP_W + 1 + $urandom_range(0, CELL_W - 1);
        py = ORG_Y + int'(cursor_row) * P + GAP_W + 1 + $urandom_range(0, CELL_W - 1);
      end else begin
        px = $urandom_range(1, 639);
        py = $urandom_range(1, 479);
      end
      v = ($urandom_range(0, 7) != 0);
      show(px, py, v);
      exp = ref_pixel(px, py, v);
      n_checks++;
      if (rgb !== exp) begin n_fail++; $display("FAIL random_%0d_%0d: rgb=%h expected %h", px, py, rgb, exp); end
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] exp_q[$];
    logic [11:0] exp;
    int px, py;
    bit v;
    row_sel = 4'($urandom); col_sel = 4'($urandom);
    for (int n = 0; n < 202; n++) begin
      @(negedge clk);
      if (exp_q.size() >= 2) begin
        exp = exp_q.pop_front();
        n_checks++;
        if (rgb !== exp) begin n_fail++; $display("FAIL stream_%0d: rgb=%h expected %h", n, rgb, exp); end
      end
      if (n < 200) begin
        px = $urandom_range(1, 639);
        py = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 29) : $urandom_range(1, 479);
        v  = ($urandom_range(0, 9) != 0);
        x = 10'(px); y = 10'(py); videoOn = v;
        exp_q.push_back(ref_pixel(px, py, v));
      end else begin
        exp_q.push_back(12'h000);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_checks = 0; n_fail = 0;
    m_ticks = 0; m_rise = 0; m_err = 0;
    reset = 1'b0; x = 10'd1; y = 10'd1; videoOn = 1'b1;
    cells = '0; row_sel = '0; col_sel = '0;
    cursor_en = 1'b0; cursor_row = '0; cursor_col = '0; error = 1'b0;
    test_reset();
    test_regions();
    test_marks();
    test_cursor();
    test_error();
    test_reset_flash();
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
